// File: rtl/pipe_stall_flush_ctrl.sv
// Central pipeline controller.
//
// Builds the per-stage hold vector from the per-stage stall requests, derives
// the 2-bit {upstream,downstream} stall code for every stage boundary, and
// sequences exception/ERET recovery: a one-cycle flush pulse followed by a PC
// redirect to fetch that is held until fetch acknowledges it.
//
// Handshake: redirect_valid/redirect_ack follow valid/ready rules. Once
// redirect_valid rises, it and redirect_pc stay constant until the cycle in
// which redirect_ack is high. That cycle completes the transfer. An ack seen
// while redirect_valid is low is ignored.
module pipe_stall_flush_ctrl #(
  parameter int                N_STAGE    = 6,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
  parameter int                CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_STAGE-1:0]       stallreq,
  input  logic                     exc_valid,
  input  logic                     exc_eret,
  input  logic [ADDR_W-1:0]        exc_epc,
  input  logic                     redirect_ack,
  output logic [N_STAGE-1:0]       stall,
  output logic [2*(N_STAGE-1)-1:0] stall_bus,
  output logic                     flush,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [N_STAGE-1:0]  stall_raw;

  // State, captured redirect target and stall counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Recovery sequencing. The redirect target is captured only when a new
  // sequence starts, so it cannot move while redirect_valid is high.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d       = ST_FLUSH;
          redirect_pc_d = exc_eret ? exc_epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        state_d = redirect_ack ? ST_IDLE : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (redirect_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating count of cycles in which any stage requested a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|stallreq) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // A held stage holds every stage upstream of it. While fetch waits for the
  // redirect acknowledge, IF is also held so it does not run off the old path.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_raw = '0;
    for (int i = N_STAGE - 1; i >= 0; i--) begin
      acc          = acc | stallreq[i];
      stall_raw[i] = acc;
    end
    if (state_q == ST_WAIT_ACK) stall_raw[0] = 1'b1;
    stall = resetn ? stall_raw : '0;
  end

  // Boundary k sits between stage k and stage k+1: {upstream, downstream}.
  // Because of the upstream propagation above, {0,1} cannot be produced.
  for (genvar k = 0; k < N_STAGE - 1; k++) begin : g_bus
    assign stall_bus[2*k+1] = stall[k];
    assign stall_bus[2*k]   = stall[k+1];
  end

  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q != ST_IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign stall_cnt      = stall_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Bench for pipe_stall_flush_ctrl: table-driven stall vectors plus
// hand-written recovery and counter sequences.
module tb_pipe_stall_flush_ctrl;

  localparam int N_STAGE = 6;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 16;
  localparam int BUS_W   = 2 * (N_STAGE - 1);

  // Clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [N_STAGE-1:0] stallreq;
  logic               exc_valid;
  logic               exc_eret;
  logic [ADDR_W-1:0]  exc_epc;
  logic               redirect_ack;
  logic [N_STAGE-1:0] stall;
  logic [BUS_W-1:0]   stall_bus;
  logic               flush;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [CNT_W-1:0]   stall_cnt;
  logic [1:0]         dbg_state;

  pipe_stall_flush_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .stallreq       (stallreq),
    .exc_valid      (exc_valid),
    .exc_eret       (exc_eret),
    .exc_epc        (exc_epc),
    .redirect_ack   (redirect_ack),
    .stall          (stall),
    .stall_bus      (stall_bus),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cnt      (stall_cnt),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic [N_STAGE-1:0] req;
    logic [N_STAGE-1:0] exp_stall;
    logic [BUS_W-1:0]   exp_bus;
  } vec_t;

  vec_t vecs[6];

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the
  // falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Boundary codes listed k=4 .. k=0
    vecs[0] = '{6'b000000, 6'b000000, 10'b00_00_00_00_00};
    vecs[1] = '{6'b001000, 6'b001111, 10'b00_10_11_11_11};
    vecs[2] = '{6'b000001, 6'b000001, 10'b00_00_00_00_10};
    vecs[3] = '{6'b100000, 6'b111111, 10'b11_11_11_11_11};
    vecs[4] = '{6'b010100, 6'b011111, 10'b10_11_11_11_11};
    vecs[5] = '{6'b000110, 6'b000111, 10'b00_00_10_11_11};

    resetn = 1'b0; stallreq = 6'b111111; exc_valid = 1'b0; exc_eret = 1'b0;
    exc_epc = '0; redirect_ack = 1'b0;
    repeat (3) tick();
    mid();
    chk("stall_in_reset", 64'(stall), 64'(0));
    chk("bus_in_reset", 64'(stall_bus), 64'(0));

    tick(); resetn = 1'b1; stallreq = '0;
    mid();
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_rvalid", 64'(redirect_valid), 64'(0));
    chk("rst_pc", 64'(redirect_pc), 64'(0));
    chk("rst_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));

    // Stall vector table
    for (int i = 0; i < 6; i++) begin
      tick(); stallreq = vecs[i].req;
      mid();
      chk($sformatf("stall_v%0d", i), 64'(stall), 64'(vecs[i].exp_stall));
      chk($sformatf("bus_v%0d", i), 64'(stall_bus), 64'(vecs[i].exp_bus));
    end
    tick(); stallreq = '0;
    mid();
    chk("cnt_after_table", 64'(stall_cnt), 64'(5));

    // General exception, immediate ack
    tick(); exc_valid = 1'b1; exc_eret = 1'b0; exc_epc = 32'h11112222;
    mid();
    chk("exc_pre_flush", 64'(flush), 64'(0));
    tick(); exc_valid = 1'b0; redirect_ack = 1'b1;
    mid();
    chk("exc_flush", 64'(flush), 64'(1));
    chk("exc_rvalid", 64'(redirect_valid), 64'(1));
    chk("exc_pc", 64'(redirect_pc), 64'(32'hBFC00380));
    tick(); redirect_ack = 1'b0;
    mid();
    chk("exc_flush_done", 64'(flush), 64'(0));
    chk("exc_rvalid_done", 64'(redirect_valid), 64'(0));

    // Ack with no pending redirect does nothing
    tick(); redirect_ack = 1'b1;
    tick(); redirect_ack = 1'b0;
    mid();
    chk("stray_ack_idle", 64'(dbg_state), 64'(0));

    // ERET with ack withheld; epc changes after capture
    tick(); exc_valid = 1'b1; exc_eret = 1'b1; exc_epc = 32'h80001234;
    tick(); exc_valid = 1'b0; exc_eret = 1'b0; exc_epc = 32'hDEADBEEF;
    mid();
    chk("eret_flush", 64'(flush), 64'(1));
    chk("eret_rvalid", 64'(redirect_valid), 64'(1));
    chk("eret_pc", 64'(redirect_pc), 64'(32'h80001234));
    for (int i = 0; i < 3; i++) begin
      tick(); redirect_ack = (i == 2);
      mid();
      chk($sformatf("eret_wait_flush%0d", i), 64'(flush), 64'(0));
      chk($sformatf("eret_wait_rvalid%0d", i), 64'(redirect_valid), 64'(1));
      chk($sformatf("eret_wait_stall%0d", i), 64'(stall), 64'(6'b000001));
      chk($sformatf("eret_wait_pc%0d", i), 64'(redirect_pc), 64'(32'h80001234));
    end
    tick(); redirect_ack = 1'b0;
    mid();
    chk("eret_done_rvalid", 64'(redirect_valid), 64'(0));
    chk("eret_done_stall", 64'(stall), 64'(0));

    // Exception during WAIT_ACK is ignored; then back-to-back restart
    tick(); exc_valid = 1'b1; exc_eret = 1'b1; exc_epc = 32'h80001234;
    tick(); exc_valid = 1'b0;
    tick(); exc_valid = 1'b1; exc_epc = 32'h12345678;
    mid();
    chk("ign_state_wait", 64'(dbg_state), 64'(2));
    tick();
    mid();
    chk("ign_no_flush", 64'(flush), 64'(0));
    chk("ign_pc", 64'(redirect_pc), 64'(32'h80001234));
    tick(); exc_valid = 1'b0; redirect_ack = 1'b1;
    mid();
    chk("ign_pc_ack", 64'(redirect_pc), 64'(32'h80001234));
    tick(); redirect_ack = 1'b0; exc_valid = 1'b1; exc_eret = 1'b0;
    mid();
    chk("b2b_idle_gap", 64'(redirect_valid), 64'(0));
    tick(); exc_valid = 1'b0; redirect_ack = 1'b1;
    mid();
    chk("b2b_flush", 64'(flush), 64'(1));
    chk("b2b_pc", 64'(redirect_pc), 64'(32'hBFC00380));
    tick(); redirect_ack = 1'b0;
    mid();
    chk("b2b_done", 64'(redirect_valid), 64'(0));

    // Exception with a concurrent stall request still starts recovery
    tick(); exc_valid = 1'b1; stallreq = 6'b001000;
    mid();
    chk("exc_stall_comb", 64'(stall), 64'(6'b001111));
    tick(); exc_valid = 1'b0; stallreq = '0;
    mid();
    chk("exc_stall_flush", 64'(flush), 64'(1));

    // Reset while waiting for ack
    tick();
    mid();
    chk("rst_mid_wait", 64'(dbg_state), 64'(2));
    tick(); resetn = 1'b0;
    mid();
    chk("rst_mid_stall_gated", 64'(stall), 64'(0));
    tick(); resetn = 1'b1;
    mid();
    chk("rst_mid_state", 64'(dbg_state), 64'(0));
    chk("rst_mid_rvalid", 64'(redirect_valid), 64'(0));
    chk("rst_mid_flush", 64'(flush), 64'(0));
    chk("rst_mid_stall", 64'(stall), 64'(0));

    // Counter saturation
    tick(); stallreq = 6'b000100;
    repeat (65534) tick();
    mid();
    chk("cnt_fffe", 64'(stall_cnt), 64'(16'hFFFE));
    repeat (3) tick();
    mid();
    chk("cnt_sat", 64'(stall_cnt), 64'(16'hFFFF));
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1; stallreq = '0;
    mid();
    chk("cnt_cleared", 64'(stall_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
